// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared encodings for the E-stage multiply/divide unit.
//                md_op values are also emitted by the CU decoder, so both
//                sides stay in step through this package.
//                Contents: MD_* 3-bit operation codes, the IDLE/RUN state
//                type, and small op-classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_if
//  Description : Issue/result bundle between the E stage and md_unit.
//                master : E stage / stall controller side
//                slave  : md_unit
//                Signals: start, md_op[2:0], src_a[31:0], src_b[31:0] (in to
//                slave); busy, md_stall_src, hi[31:0], lo[31:0] (out of slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_if;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        md_stall_src;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, src_a, src_b,
    input  busy, md_stall_src, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b,
    output busy, md_stall_src, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
//  Module      : md_arith
//  Description : Combinational datapath for mult/multu/div/divu.
//                Ports: op[2:0], a[31:0], b[31:0] in;
//                       res_hi[31:0], res_lo[31:0], keep out.
//                keep=1 means divide-by-zero: HI/LO must not be written.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_arith
  import md_pkg::*;
(
  input  wire logic [2:0]  op,
  input  wire logic [31:0] a,
  input  wire logic [31:0] b,
  output logic      [31:0] res_hi,
  output logic      [31:0] res_lo,
  output logic             keep
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;

  // Sign-extending both operands to 64 bits makes the low 64 bits of an
  // unsigned multiply equal to the two's-complement signed product.
  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes and the signs are fixed up after.
  // |0x80000000| is 0x80000000 as an unsigned value, so 0x80000000 / -1
  // naturally yields quotient 0x80000000, remainder 0.
  assign w_signed_div = (op == MD_DIV);
  assign w_a_neg      = w_signed_div & a[31];
  assign w_b_neg      = w_signed_div & b[31];
  assign w_a_mag      = w_a_neg ? (~a + 32'd1) : a;
  assign w_b_mag      = w_b_neg ? (~b + 32'd1) : b;
  // Never present a zero divisor to the divider; the result is discarded.
  assign w_b_safe     = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_a_mag / w_b_safe;
  assign w_r_mag      = w_a_mag % w_b_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    keep   = 1'b0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = w_prod_s;
      MD_MULTU: {res_hi, res_lo} = w_prod_u;
      MD_DIV, MD_DIVU: begin
        keep   = (b == 32'd0);
        res_lo = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
        res_hi = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : E-stage multiply/divide unit owning HI/LO. Runs mult/multu/
//                div/divu over a fixed latency and services mthi/mtlo.
//                Ports: clk, reset_n (async, active low), md (md_unit_if.slave:
//                start, md_op, src_a, src_b -> busy, md_stall_src, hi, lo).
//                Parameters: MULT_CYCLES, DIV_CYCLES (>= 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  md_unit_if.slave    md
);

  localparam int C_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;

  md_state_t          r_state;
  md_state_t          w_state_nxt;
  logic [C_CNT_W-1:0] r_count;
  logic [C_CNT_W-1:0] w_count_nxt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_res_hi;
  logic [31:0]        r_res_lo;
  logic               r_res_keep;

  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_res_keep;
  logic               w_load_res;
  logic               w_wr_hi;
  logic               w_wr_lo;
  logic [31:0]        w_hi_d;
  logic [31:0]        w_lo_d;

  md_arith u_arith (
    .op     (md.md_op),
    .a      (md.src_a),
    .b      (md.src_b),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo),
    .keep   (w_res_keep)
  );

  // Next-state / control
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_load_res  = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    w_hi_d      = r_hi;
    w_lo_d      = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (md.start && is_mul_op(md.md_op)) begin
          w_state_nxt = ST_RUN;
          w_count_nxt = C_CNT_W'(MULT_CYCLES - 1);
          w_load_res  = 1'b1;
        end else if (md.start && is_div_op(md.md_op)) begin
          w_state_nxt = ST_RUN;
          w_count_nxt = C_CNT_W'(DIV_CYCLES - 1);
          w_load_res  = 1'b1;
        end else if (!md.start && md.md_op == MD_MTHI) begin
          w_wr_hi = 1'b1;
          w_hi_d  = md.src_a;
        end else if (!md.start && md.md_op == MD_MTLO) begin
          w_wr_lo = 1'b1;
          w_lo_d  = md.src_a;
        end
      end
      ST_RUN: begin
        // start/mthi/mtlo arriving here are dropped: the stall controller
        // holds them in D while busy, so they only appear on a protocol bug.
        if (r_count == '0) begin
          w_state_nxt = ST_IDLE;
          if (!r_res_keep) begin
            w_wr_hi = 1'b1;
            w_wr_lo = 1'b1;
            w_hi_d  = r_res_hi;
            w_lo_d  = r_res_lo;
          end
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_res_hi   <= 32'd0;
      r_res_lo   <= 32'd0;
      r_res_keep <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_load_res) begin
        r_res_hi   <= w_res_hi;
        r_res_lo   <= w_res_lo;
        r_res_keep <= w_res_keep;
      end
      if (w_wr_hi) r_hi <= w_hi_d;
      if (w_wr_lo) r_lo <= w_lo_d;
    end
  end

  assign md.busy         = (r_state == ST_RUN);
  // Include start so a dependent md instruction in D stalls in the issue
  // cycle itself, before busy has had a chance to rise.
  assign md.md_stall_src = md.start | md.busy;
  assign md.hi           = r_hi;
  assign md.lo           = r_lo;

  // Flags an issue that slipped past the stall controller (warning only;
  // the unit itself simply ignores it).
  always @(posedge clk) begin
    if (reset_n && md.start && r_state == ST_RUN)
      $warning("md_unit: start while busy ignored");
  end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Directed self-checking bench for md_unit.
//                Inputs driven and outputs sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;
  import md_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  md_unit_if ifc ();

  md_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check busy/stall across its whole latency.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.md_op = op;
    ifc.src_a = a;
    ifc.src_b = b;
    #1;
    chk({tag, ".stall_T"}, 32'(ifc.md_stall_src), 32'd1);
    chk({tag, ".busy_T"},  32'(ifc.busy),         32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      ifc.md_op = MD_NONE;
      #1;
      chk({tag, ".busy_run"},  32'(ifc.busy),         32'd1);
      chk({tag, ".stall_run"}, 32'(ifc.md_stall_src), 32'd1);
    end
    @(negedge clk);
    chk({tag, ".busy_done"},  32'(ifc.busy),         32'd0);
    chk({tag, ".stall_done"}, 32'(ifc.md_stall_src), 32'd0);
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] v);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.md_op = op;
    ifc.src_a = v;
    @(negedge clk);
    ifc.md_op = MD_NONE;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    ifc.start = 1'b0;
    ifc.md_op = MD_NONE;
    ifc.src_a = 32'd0;
    ifc.src_b = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst.busy",  32'(ifc.busy),         32'd0);
    chk("rst.stall", 32'(ifc.md_stall_src), 32'd0);
    chk("rst.hi",    ifc.hi,                32'd0);
    chk("rst.lo",    ifc.lo,                32'd0);
    reset_n = 1'b1;

    // MTHI in IDLE: visible the next cycle, never busy
    @(negedge clk);
    ifc.md_op = MD_MTHI;
    ifc.src_a = 32'h0000_ABCD;
    #1;
    chk("mthi.busy0", 32'(ifc.busy), 32'd0);
    @(negedge clk);
    ifc.md_op = MD_NONE;
    chk("mthi.hi",    ifc.hi,        32'h0000_ABCD);
    chk("mthi.busy1", 32'(ifc.busy), 32'd0);
    chk("mthi.lo",    ifc.lo,        32'd0);
    move_to(MD_MTLO, 32'h0000_1234);
    chk("mtlo.lo", ifc.lo, 32'h0000_1234);

    // NONE with no start changes nothing
    repeat (2) @(negedge clk);
    chk("none.hi", ifc.hi, 32'h0000_ABCD);
    chk("none.lo", ifc.lo, 32'h0000_1234);

    // Reset mid-divide: abort immediately, no late write afterwards
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.md_op = MD_DIV;
    ifc.src_a = 32'd100;
    ifc.src_b = 32'd7;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.md_op = MD_NONE;
    repeat (2) @(negedge clk);
    chk("abort.busy_pre", 32'(ifc.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort.busy", 32'(ifc.busy), 32'd0);
    chk("abort.hi",   ifc.hi,        32'd0);
    chk("abort.lo",   ifc.lo,        32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (DIV_N + 2) @(negedge clk);
    chk("abort.hi_late", ifc.hi,        32'd0);
    chk("abort.lo_late", ifc.lo,        32'd0);
    chk("abort.busy_late", 32'(ifc.busy), 32'd0);

    // Multiplies
    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, MULT_N);
    chk("mult.hi", ifc.hi, 32'hFFFF_FFFF);
    chk("mult.lo", ifc.lo, 32'hFFFF_FFFA);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, MULT_N);
    chk("multu.hi", ifc.hi, 32'h0000_0002);
    chk("multu.lo", ifc.lo, 32'hFFFF_FFFA);

    // Divides
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N);
    chk("div.hi", ifc.hi, 32'hFFFF_FFFF);
    chk("div.lo", ifc.lo, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'd7, 32'd2, DIV_N);
    chk("divu.hi", ifc.hi, 32'd1);
    chk("divu.lo", ifc.lo, 32'd3);
    run_op("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
    chk("divovf.hi", ifc.hi, 32'd0);
    chk("divovf.lo", ifc.lo, 32'h8000_0000);

    // Divide by zero keeps preloaded HI/LO
    move_to(MD_MTHI, 32'h0000_0011);
    move_to(MD_MTLO, 32'h0000_0022);
    run_op("div0", MD_DIV, 32'd5, 32'd0, DIV_N);
    chk("div0.hi", ifc.hi, 32'h0000_0011);
    chk("div0.lo", ifc.lo, 32'h0000_0022);

    // start and MTLO during RUN are both ignored; original result lands on time
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.md_op = MD_MULT;
    ifc.src_a = 32'd3;
    ifc.src_b = 32'd4;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.md_op = MD_NONE;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.md_op = MD_DIVU;
    ifc.src_a = 32'd100;
    ifc.src_b = 32'd3;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.md_op = MD_MTLO;
    ifc.src_a = 32'h0000_5555;
    @(negedge clk);
    ifc.md_op = MD_NONE;
    chk("ovl.lo_mid", ifc.lo, 32'h0000_0022);
    @(negedge clk);
    chk("ovl.busy_last", 32'(ifc.busy), 32'd1);
    @(negedge clk);
    chk("ovl.busy_end", 32'(ifc.busy), 32'd0);
    chk("ovl.hi",       ifc.hi,        32'd0);
    chk("ovl.lo",       ifc.lo,        32'd12);
    repeat (DIV_N) @(negedge clk);
    chk("ovl.lo_late",  ifc.lo,        32'd12);
    chk("ovl.busy_late", 32'(ifc.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
